// File: rtl/divider_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
// The master is the execute stage. The slave is the divider itself.
interface divider_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            flush_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, flush_i, op_i, a_i, b_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, flush_i, op_i, a_i, b_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It retires one quotient bit per cycle on magnitudes and then applies sign correction.
// Optional macro DIV_EARLY_EXIT_EN: divide-by-zero and signed overflow finish straight from IDLE.
// Without that macro, those cases fall out of the normal datapath.
module divider #(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    divider_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] bAbs;
    logic [XLEN-1:0] result;
    logic            aNeg;
    logic            bNeg;
    logic            bZero;
    logic            isRem;

    logic            startOk;
    logic            inSigned;
    logic            inANeg;
    logic            inBNeg;
    logic [XLEN-1:0] inAAbs;
    logic [XLEN-1:0] inBAbs;
    logic            inBZero;

    logic [XLEN:0]   remShift;
    logic            remGe;
    logic [XLEN-1:0] remNext;
    logic            negQ;
    logic [XLEN-1:0] quoFix;
    logic [XLEN-1:0] remFix;

`ifdef DIV_EARLY_EXIT_EN
    logic            inSpecial;
    logic [XLEN-1:0] specialResult;
`endif

    assign bus.busy_o   = (state != IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result;

    // Decode the operands presented with start.
    // Only DIV/REM take magnitudes. The sign flags already fold in signedness.
    always_comb begin
        startOk  = bus.start_i & ~bus.flush_i;
        inSigned = ~bus.op_i[0];
        inANeg   = inSigned & bus.a_i[XLEN-1];
        inBNeg   = inSigned & bus.b_i[XLEN-1];
        inAAbs   = inANeg ? -bus.a_i : bus.a_i;
        inBAbs   = inBNeg ? -bus.b_i : bus.b_i;
        inBZero  = (bus.b_i == '0);
    end

`ifdef DIV_EARLY_EXIT_EN
    // Detect the two special cases and form their architectural results directly.
    always_comb begin
        inSpecial     = inBZero | (inSigned & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b_i));
        specialResult = '0;
        if (inBZero) begin
            specialResult = bus.op_i[1] ? bus.a_i : '1;
        end else begin
            specialResult = bus.op_i[1] ? '0 : bus.a_i;
        end
    end
`endif

    // One restoring step. The compare is one bit wider so a dividend magnitude of 2^(XLEN-1) is safe.
    // The difference always fits in XLEN bits when the compare succeeds.
    always_comb begin
        remShift = {rem, quo[XLEN-1]};
        remGe    = (remShift >= {1'b0, bAbs});
        remNext  = remGe ? (remShift[XLEN-1:0] - bAbs) : remShift[XLEN-1:0];
        negQ     = (aNeg ^ bNeg) & ~bZero;
        quoFix   = negQ ? -quo : quo;
        remFix   = aNeg ? -rem : rem;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Flush overrides every transition.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startOk) begin
`ifdef DIV_EARLY_EXIT_EN
                    nextState = inSpecial ? DONE : CALC;
`else
                    nextState = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    nextState = FIX;
                end
            end
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (bus.flush_i) begin
            nextState = IDLE;
        end
    end

    // Datapath. A flushed cycle changes nothing, so result keeps its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            bAbs   <= '0;
            result <= '0;
            aNeg   <= 1'b0;
            bNeg   <= 1'b0;
            bZero  <= 1'b0;
            isRem  <= 1'b0;
        end else if (!bus.flush_i) begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        aNeg  <= inANeg;
                        bNeg  <= inBNeg;
                        bZero <= inBZero;
                        isRem <= bus.op_i[1];
                        quo   <= inAAbs;
                        bAbs  <= inBAbs;
                        rem   <= '0;
                        cnt   <= CW'(XLEN-1);
`ifdef DIV_EARLY_EXIT_EN
                        if (inSpecial) begin
                            result <= specialResult;
                        end
`endif
                    end
                end
                CALC: begin
                    quo <= {quo[XLEN-2:0], remGe};
                    rem <= remNext;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    result <= isRem ? remFix : quoFix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: a directed vector table plus hand-written flush, reset and handshake sequences.
module tb_divider;
    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    divider_if #(.XLEN(32)) bus ();

    divider #(.XLEN(32)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    vec_t tbl[18];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Runs one operation. The operands are scrambled after the accept edge.
    // vEdge is the index k of the edge Ek after which valid_o was first seen, or -1 on timeout.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int vEdge);
        res   = '0;
        vEdge = -1;
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk_i);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                bus.start_i = 1'b0;
                bus.a_i     = $urandom;
                bus.b_i     = $urandom;
                bus.op_i    = 2'($urandom);
            end
            if (bus.valid_o) begin
                vEdge = k;
                res   = bus.result_o;
                break;
            end
            @(posedge clk_i);
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] lastExp;
        int          vEdge;
        int          expEdge;
        int          nValid;
        int          vEdges[3];
        logic        sawValid;

        checks   = 0;
        failures = 0;

        tbl[0]  = '{2'b00, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0};
        tbl[1]  = '{2'b10, 32'd20,        32'hFFFFFFFD, 32'h00000002, 1'b0};
        tbl[2]  = '{2'b01, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 1'b0};
        tbl[3]  = '{2'b11, 32'hFFFFFFFF,  32'd2,        32'h00000001, 1'b0};
        tbl[4]  = '{2'b00, 32'd7,         32'd0,        32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'b00, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 1'b1};
        tbl[6]  = '{2'b10, 32'd7,         32'd0,        32'h00000007, 1'b1};
        tbl[7]  = '{2'b11, 32'h80000000,  32'd0,        32'h80000000, 1'b1};
        tbl[8]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
        tbl[9]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[10] = '{2'b00, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0};
        tbl[11] = '{2'b10, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0};
        tbl[12] = '{2'b01, 32'd100,       32'd7,        32'd14,       1'b0};
        tbl[13] = '{2'b11, 32'd100,       32'd7,        32'd2,        1'b0};
        tbl[14] = '{2'b01, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[15] = '{2'b11, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0};
        tbl[16] = '{2'b01, 32'd7,         32'd0,        32'hFFFFFFFF, 1'b1};
        tbl[17] = '{2'b00, 32'h80000000,  32'd1,        32'h80000000, 1'b0};

        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        rst_ni      = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        $display("[TB] reset state");
        checkOutput("reset busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("reset valid", {31'b0, bus.valid_o}, 32'd0);
        checkOutput("reset result", bus.result_o, 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 18; i++) begin
`ifdef DIV_EARLY_EXIT_EN
            expEdge = tbl[i].special ? 0 : 33;
`else
            expEdge = 33;
`endif
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, res, vEdge);
            checkOutput($sformatf("vec%0d result", i), res, tbl[i].exp);
            checkOutput($sformatf("vec%0d valid edge", i), 32'(vEdge), 32'(expEdge));
            @(negedge clk_i);
            checkOutput($sformatf("vec%0d valid one cycle", i), {31'b0, bus.valid_o}, 32'd0);
            checkOutput($sformatf("vec%0d busy after done", i), {31'b0, bus.busy_o}, 32'd0);
        end
        lastExp = tbl[17].exp;

        $display("[TB] flush at E10");
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        checkOutput("busy before flush", {31'b0, bus.busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk_i);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        checkOutput("busy after flush", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("result after flush", bus.result_o, lastExp);
        sawValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.valid_o || bus.busy_o) sawValid = 1'b1;
        end
        checkOutput("no valid or busy after flush", {31'b0, sawValid}, 32'd0);
        checkOutput("result still held", bus.result_o, lastExp);

        $display("[TB] divu after flush");
        applyStimulus(2'b01, 32'd100, 32'd7, res, vEdge);
        checkOutput("post-flush divu result", res, 32'd14);
        checkOutput("post-flush divu valid edge", 32'(vEdge), 32'd33);

        $display("[TB] reset mid-operation");
        @(negedge clk_i);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'd50;
        bus.b_i     = 32'd5;
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("mid reset busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("mid reset valid", {31'b0, bus.valid_o}, 32'd0);
        checkOutput("mid reset result", bus.result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bus.valid_o) sawValid = 1'b1;
        end
        checkOutput("no valid after reset", {31'b0, sawValid}, 32'd0);

        $display("[TB] start held high");
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'd20;
        bus.b_i     = 32'hFFFFFFFD;
        nValid = 0;
        for (int k = 0; k < 106; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (bus.valid_o) begin
                if (nValid < 3) vEdges[nValid] = k;
                nValid++;
                checkOutput($sformatf("held start result %0d", nValid), bus.result_o, 32'hFFFFFFFA);
            end
        end
        bus.start_i = 1'b0;
        checkOutput("held start valid count", 32'(nValid), 32'd3);
        if (nValid >= 3) begin
            checkOutput("held start first edge", 32'(vEdges[0]), 32'd33);
            checkOutput("held start spacing 1", 32'(vEdges[1] - vEdges[0]), 32'd35);
            checkOutput("held start spacing 2", 32'(vEdges[2] - vEdges[1]), 32'd35);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divider.md
# divider

Iterative radix-2 integer divider for the RV32M execute stage, the sequential counterpart to the single-cycle multiplier in the mul_div unit. It accepts one DIV/DIVU/REM/REMU operation at a time, uses a start/valid handshake, and returns a RISC-V-compliant result, including divide-by-zero and signed-overflow cases. The execute stage stalls on `busy_o` and consumes `result_o` when `valid_o` pulses.

## Interface
- `XLEN`, 32: operand and result width.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `start_i` in 1: request a division; sampled only in IDLE.
- `flush_i` in 1: synchronous kill of any in-flight operation.
- `op_i` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with `start_i`.
- `a_i` in XLEN: dividend; captured with `start_i`.
- `b_i` in XLEN: divisor; captured with `start_i`.
- `busy_o` out 1: high in every state except IDLE.
- `valid_o` out 1: one-cycle result strobe.
- `result_o` out XLEN: quotient or remainder; holds its value until the next result is loaded.

## Operation
- States:
  - IDLE: `start_i` & !`flush_i` latches the signs, `|a|`, `|b|`, `op`, and the `b==0` flag. It clears the remainder register, loads `cnt = XLEN-1`, and moves to CALC.
  - CALC: one restoring step per cycle.
    - `rem = {rem, q[XLEN-1]}` and `q <<= 1`.
    - If `rem >= |b|`, then `rem -= |b|` and `q[0] = 1`.
    - Exit when `cnt == 0`, otherwise `cnt--`.
  - FIX: apply the sign corrections, register `result_o`, then go to DONE.
  - DONE: `valid_o = 1` for this cycle only; the next state is IDLE. `start_i` is ignored here.
- Absolute values are taken only for DIV/REM; DIVU/REMU use the raw operands. Use XLEN+1-bit compare/subtract so `|a| = 2^(XLEN-1)` is handled.
- Sign rules:
  - Quotient is negated iff the op is signed, `a_neg ^ b_neg`, and `b != 0`.
  - Remainder is negated iff the op is signed and `a_neg`.
- Required special results, produced by the datapath without extra cases:
  - `b==0`: quotient is all ones; remainder is `a`.
  - Signed `a = -2^(XLEN-1)`, `b = -1`: quotient is `a`; remainder is 0.
- `flush_i` has priority over everything. From any state, the next state is IDLE, `valid_o` is never asserted for the killed op, and `result_o` keeps its old value. `start_i` in the same cycle as `flush_i` is dropped.
- Reset values: state IDLE, `busy_o` 0, `valid_o` 0, `result_o` 0; all internal registers 0.
- Reset asserted mid-operation aborts immediately. No `valid_o` is produced.

## Timing
- Start accepted at edge E0.
- CALC occupies edges E1..E_XLEN; FIX is at E_XLEN+1.
- `valid_o` is high between E_XLEN+1 and E_XLEN+2, giving a latency of XLEN+1 edges (33 for XLEN=32).
- `busy_o` is high from after E0 until after E_XLEN+2.
- The earliest next start is at E_XLEN+3, so throughput is one op per XLEN+3 cycles.
- Inputs other than `start_i`/`flush_i` are don't-care outside the accept edge.

## Configuration
- `DIV_EARLY_EXIT_EN` defined: in IDLE, an accepted start with `b==0` or signed overflow loads `result_o` directly per the special-result rules and goes straight to DONE. `valid_o` is then high after E0, a latency of 1 edge. All other ops are unchanged.
- Not defined: every op takes the full XLEN+1 latency. Special results come from the iterative datapath plus the sign rules. No special-case logic is instantiated.

## Test plan
- DIV `a = 20`, `b = 0xFFFFFFFD` (-3) -> `result_o = 0xFFFFFFFA`. REM with the same operands -> `0x00000002`. `valid_o` is high exactly after edge E33.
- DIVU `a = 0xFFFFFFFF`, `b = 2` -> `0x7FFFFFFF`. REMU with the same operands -> `0x00000001`.
- Divide by zero (latency 33 without the macro, 1 with it):
  - DIV 7/0 -> `0xFFFFFFFF`.
  - DIV `0xFFFFFFF9`/0 -> `0xFFFFFFFF`.
  - REM 7/0 -> `0x00000007`.
  - REMU `0x80000000`/0 -> `0x80000000`.
- Signed overflow: DIV `0x80000000`/`0xFFFFFFFF` -> `0x80000000`; REM with the same operands -> `0x00000000`.
- Flush and reset:
  - Start DIVU 100/7, pulse `flush_i` at E10 -> `busy_o` low after E10, no `valid_o`, `result_o` unchanged.
  - A new DIVU 100/7 then yields 14.
  - `rst_ni` low at E5 of another op -> all outputs 0 immediately.
- Handshake:
  - `start_i` held high continuously -> an accept at IDLE only, with no start in CALC, FIX or DONE. Results are spaced exactly 35 cycles apart.
  - Operand changes during CALC -> no effect on the result.
